// File: rtl/codificador_instr.sv
// RV32I instruction encoder/loader: packs decoded fields into a 32-bit word
// and writes it to instruction memory at consecutive word addresses.
module codificador_instr #(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic                r_err;
  logic                w_xfer;
  logic                w_legal;
  logic [31:0]         w_enc;
  logic [ADDR_W:0]     w_count_inc;

  assign in_ready    = (r_state == S_IDLE) && !r_full && !clear;
  assign w_xfer      = in_valid && in_ready;
  assign w_legal     = (fmt <= 3'd5);
  assign w_count_inc = r_count + (ADDR_W+1)'(1);

  always_comb begin
    w_enc = 32'd0;
    case (fmt)
      3'd0: w_enc = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: w_enc = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: w_enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: w_enc = {imm[31:12], rd, opcode};
      3'd5: w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_enc = 32'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer && w_legal) w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // clear is only honoured in S_IDLE so an in-flight write always completes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
    end else if (r_state == S_WRITE) begin
      r_mem_we <= 1'b0;
      r_count  <= w_count_inc;
      r_full   <= (w_count_inc == DEPTH_W);
    end else if (clear) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_xfer) begin
      if (w_legal) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_count[ADDR_W-1:0];
        r_mem_wdata <= w_enc;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign count     = r_count;
  assign full      = r_full;
  assign err       = r_err;

endmodule

// File: tb/tb_codificador_instr.sv
// Directed plus randomized bench for codificador_instr with a field-packing
// reference model built from shifts and masks.
module tb_codificador_instr;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              clear;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int vectors;
  int miscompares;
  int mCount;
  int mErr;
  int mAddr;
  logic [31:0] mData;

  codificador_instr #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .clear(clear),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference packing: each field is masked and shifted into its bit slot
  function automatic logic [31:0] refEnc(input int f, input logic [31:0] op,
    input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] d,
    input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] im);
    logic [31:0] common;
    common = op | (d << 7);
    case (f)
      0: return (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | common;
      1: return ((im & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | common;
      2: return (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15)
                | (f3 << 12) | ((im & 32'h1F) << 7) | op;
      3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                | (s2 << 20) | (s1 << 15) | (f3 << 12)
                | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | op;
      4: return (im & 32'hFFFFF000) | common;
      5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | common;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One field set from an idle negedge; legal formats take two cycles, illegal one
  task automatic applyStimulus(input int f, input int op, input int f3, input int f7,
    input int d, input int s1, input int s2, input logic [31:0] im,
    input logic [31:0] expWord, input bit hold);
    fmt = 3'(f); opcode = 7'(op); funct3 = 3'(f3); funct7 = 7'(f7);
    rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = im;
    in_valid = 1'b1;
    #1;
    checkOutput("in_ready_idle", 32'(in_ready), 32'(mCount != DEPTH));
    if (f <= 5) begin
      @(negedge clock);
      mAddr = mCount;
      mData = expWord;
      checkOutput("we_pulse", 32'(mem_we), 32'd1);
      checkOutput("addr", 32'(mem_addr), 32'(mAddr));
      checkOutput("wdata", mem_wdata, mData);
      checkOutput("in_ready_write", 32'(in_ready), 32'd0);
      checkOutput("count_during_write", 32'(count), 32'(mCount));
      checkOutput("err_during_write", 32'(err), 32'(mErr));
      if (!hold) in_valid = 1'b0;
      @(negedge clock);
      mCount++;
      checkOutput("we_drop", 32'(mem_we), 32'd0);
      checkOutput("count_inc", 32'(count), 32'(mCount));
      checkOutput("full", 32'(full), 32'(mCount == DEPTH));
      checkOutput("addr_hold", 32'(mem_addr), 32'(mAddr));
      checkOutput("wdata_hold", mem_wdata, mData);
    end else begin
      @(negedge clock);
      mErr = 1;
      if (!hold) in_valid = 1'b0;
      checkOutput("illegal_no_we", 32'(mem_we), 32'd0);
      checkOutput("illegal_err", 32'(err), 32'd1);
      checkOutput("illegal_count", 32'(count), 32'(mCount));
    end
  endtask

  task automatic doClear(input bit withValid);
    clear = 1'b1;
    in_valid = withValid;
    fmt = 3'd0;
    #1;
    checkOutput("in_ready_clear", 32'(in_ready), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    in_valid = 1'b0;
    mCount = 0;
    mErr = 0;
    checkOutput("clear_no_we", 32'(mem_we), 32'd0);
    checkOutput("clear_count", 32'(count), 32'd0);
    checkOutput("clear_full", 32'(full), 32'd0);
    checkOutput("clear_err", 32'(err), 32'd0);
  endtask

  initial begin
    int f;
    logic [31:0] rim;
    int rop, rf3, rf7, rrd, rr1, rr2;
    vectors = 0; miscompares = 0; mCount = 0; mErr = 0; mAddr = 0; mData = 0;
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0;
    fmt = 0; opcode = 0; funct3 = 0; funct7 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;

    @(negedge clock);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(0, 'h33, 0, 0, 3, 1, 2, 32'd0, 32'h002081B3, 1'b0);
    doClear(1'b0);

    applyStimulus(1, 'h13, 0, 0, 5, 0, 0, 32'hFFFFFFFF, 32'hFFF00293, 1'b1);
    applyStimulus(2, 'h23, 2, 0, 0, 1, 2, 32'd8,        32'h0020A423, 1'b1);
    applyStimulus(3, 'h63, 0, 0, 0, 1, 2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b1);
    applyStimulus(4, 'h37, 0, 0, 10, 0, 0, 32'h12345000, 32'h12345537, 1'b1);
    applyStimulus(5, 'h6F, 0, 0, 1, 0, 0, 32'h00000800, 32'h001000EF, 1'b0);

    applyStimulus(6, 'h33, 0, 0, 1, 1, 1, 32'd0, 32'd0, 1'b0);
    applyStimulus(0, 'h33, 0, 'h20, 7, 6, 5, 32'd0, refEnc(0, 'h33, 0, 'h20, 7, 6, 5, 0), 1'b0);
    applyStimulus(1, 'h13, 3, 0, 9, 8, 0, 32'h7FF, refEnc(1, 'h13, 3, 0, 9, 8, 0, 32'h7FF), 1'b0);
    applyStimulus(4, 'h17, 0, 0, 4, 0, 0, 32'hABCDE000, refEnc(4, 'h17, 0, 0, 4, 0, 0, 32'hABCDE000), 1'b0);
    checkOutput("full_set", 32'(full), 32'd1);

    fmt = 3'd0; in_valid = 1'b1;
    #1;
    checkOutput("full_ready", 32'(in_ready), 32'd0);
    repeat (2) begin
      @(negedge clock);
      checkOutput("full_no_we", 32'(mem_we), 32'd0);
      checkOutput("full_count", 32'(count), 32'(DEPTH));
    end
    in_valid = 1'b0;
    doClear(1'b0);

    applyStimulus(0, 'h33, 0, 0, 3, 1, 2, 32'd0, 32'h002081B3, 1'b0);
    applyStimulus(1, 'h13, 0, 0, 5, 0, 0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0);
    doClear(1'b1);
    checkOutput("clear_prio_addr", 32'(mem_addr), 32'(mAddr));
    applyStimulus(5, 'h6F, 0, 0, 1, 0, 0, 32'h00000800, 32'h001000EF, 1'b0);

    fmt = 3'd2; opcode = 7'h23; imm = 32'h0; in_valid = 1'b1;
    @(negedge clock);
    checkOutput("pre_reset_we", 32'(mem_we), 32'd1);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_we", 32'(mem_we), 32'd0);
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("async_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    mCount = 0; mErr = 0;
    @(negedge clock);
    applyStimulus(3, 'h63, 1, 0, 0, 4, 5, 32'h00001FFE, refEnc(3, 'h63, 1, 0, 0, 4, 5, 32'h00001FFE), 1'b0);

    for (int i = 0; i < 60; i++) begin
      if (mCount == DEPTH || $urandom_range(0, 11) == 0) begin
        doClear($urandom_range(0, 1) == 1);
      end else begin
        f   = $urandom_range(0, 7);
        rop = $urandom_range(0, 127); rf3 = $urandom_range(0, 7);
        rf7 = $urandom_range(0, 127); rrd = $urandom_range(0, 31);
        rr1 = $urandom_range(0, 31);  rr2 = $urandom_range(0, 31);
        rim = $urandom;
        applyStimulus(f, rop, rf3, rf7, rrd, rr1, rr2, rim,
                      refEnc(f, rop, rf3, rf7, rrd, rr1, rr2, rim), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
